// File: rtl/pcm_mm_pkg.sv
// Shared types and constants for the PCM memory-mapped request resolver.
package pcm_mm_pkg;

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        WAIT,
        RESP
    } resolver_state_t;

    localparam int CPU_AW     = 20;
    localparam int DATA_W     = 16;
    localparam int PCM_MEM_AW = 11;

    localparam logic [1:0] BYTE_EN_ALL = 2'b11;

endpackage

// File: rtl/pcm_rr_arbiter.sv
// Round-robin arbiter: combinational grant of the first request at or after
// the pointer (wrapping), pointer moves past the grant when it is taken.
module pcm_rr_arbiter #(
    parameter int NUM_REQ = 4,
    localparam int PW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [NUM_REQ-1:0] req,
    input  logic               advance,
    output logic               gnt_valid,
    output logic [PW-1:0]      gnt_idx
);

    logic [PW-1:0] ptr;
    logic [PW-1:0] cand;

    function automatic logic [PW-1:0] wrap_add(input logic [PW-1:0] base, input int unsigned off);
        int unsigned s;
        s = 32'(base) + off;
        return PW'(s % NUM_REQ);
    endfunction

    // Pick the first pending request at or after the pointer.
    always_comb begin
        gnt_valid = 1'b0;
        gnt_idx   = '0;
        cand      = '0;
        // Scan from farthest to nearest so the nearest set bit is the last write.
        for (int unsigned k = NUM_REQ; k > 0; k--) begin
            cand = wrap_add(ptr, k - 1);
            if (req[cand]) begin
                gnt_valid = 1'b1;
                gnt_idx   = cand;
            end
        end
    end

    // Advance the pointer to one past the granted channel.
    always_ff @(posedge clk) begin
        if (reset) begin
            ptr <= '0;
        end else if (advance && gnt_valid) begin
            ptr <= (gnt_idx == PW'(NUM_REQ - 1)) ? '0 : gnt_idx + 1'b1;
        end
    end

endmodule

// File: rtl/pcm_mm_resolver.sv
// Memory-side responder for the per-CPU PCM request registers: arbitrates
// round-robin among pending requests and runs one access at a time on the
// 2K x 16 PCM memory port. Optional macro PCM_MM_RESOLVER_STATS_EN adds
// rd_count / wr_count transaction counters.
module pcm_mm_resolver
    import pcm_mm_pkg::*;
#(
    parameter int NUM_REQ      = 4,
    parameter int READ_LATENCY = 1,
    parameter int MEM_AW       = PCM_MEM_AW
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [NUM_REQ-1:0]        schedule,
    input  logic [NUM_REQ-1:0]        req_write,
    input  logic [NUM_REQ*CPU_AW-1:0] req_addr,
    input  logic [NUM_REQ*DATA_W-1:0] req_wdata,
    output logic [NUM_REQ-1:0]        resolved,
    output logic [DATA_W-1:0]         rdata,
    output logic                      addr_err,
    output logic [MEM_AW-1:0]         mem_address,
    output logic                      mem_chipselect,
    output logic                      mem_clken,
    output logic                      mem_write,
    output logic [DATA_W-1:0]         mem_writedata,
    output logic [1:0]                mem_byteenable,
    input  logic [DATA_W-1:0]         mem_readdata
`ifdef PCM_MM_RESOLVER_STATS_EN
    ,
    output logic [15:0]               rd_count,
    output logic [15:0]               wr_count
`endif
);

    localparam int PW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    resolver_state_t      state;
    logic [PW-1:0]        grant_q;
    logic                 wr_q;
    logic                 err_q;
    logic [1:0]           wait_cnt;
    logic                 gnt_valid;
    logic [PW-1:0]        gnt_idx;
    logic [CPU_AW-1:0]    sel_addr;
    logic [DATA_W-1:0]    sel_wdata;
    logic                 sel_err;
    logic [NUM_REQ-1:0]   grant_onehot;

    assign mem_byteenable = BYTE_EN_ALL;
    assign sel_addr       = req_addr[gnt_idx*CPU_AW +: CPU_AW];
    assign sel_wdata      = req_wdata[gnt_idx*DATA_W +: DATA_W];
    assign sel_err        = |sel_addr[CPU_AW-1:MEM_AW];
    assign grant_onehot   = NUM_REQ'(1) << grant_q;

    pcm_rr_arbiter #(
        .NUM_REQ (NUM_REQ)
    ) u_arb (
        .clk       (clk),
        .reset     (reset),
        .req       (schedule),
        .advance   (state == IDLE),
        .gnt_valid (gnt_valid),
        .gnt_idx   (gnt_idx)
    );

    // Transaction FSM with registered memory strobes and response outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            state          <= IDLE;
            grant_q        <= '0;
            wr_q           <= 1'b0;
            err_q          <= 1'b0;
            wait_cnt       <= '0;
            resolved       <= '0;
            rdata          <= '0;
            addr_err       <= 1'b0;
            mem_address    <= '0;
            mem_chipselect <= 1'b0;
            mem_clken      <= 1'b0;
            mem_write      <= 1'b0;
            mem_writedata  <= '0;
`ifdef PCM_MM_RESOLVER_STATS_EN
            rd_count       <= '0;
            wr_count       <= '0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (gnt_valid) begin
                        grant_q <= gnt_idx;
                        wr_q    <= req_write[gnt_idx];
                        err_q   <= sel_err;
                        // Strobes are loaded on the grant edge so they are on the bus throughout ISSUE.
                        if (!sel_err) begin
                            mem_chipselect <= 1'b1;
                            mem_clken      <= 1'b1;
                            mem_write      <= req_write[gnt_idx];
                            mem_address    <= sel_addr[MEM_AW-1:0];
                            mem_writedata  <= sel_wdata;
                        end
                        state <= ISSUE;
                    end
                end
                ISSUE: begin
                    mem_chipselect <= 1'b0;
                    mem_write      <= 1'b0;
                    if (wr_q || err_q) begin
                        mem_clken <= 1'b0;
                        rdata     <= '0;
                        resolved  <= grant_onehot;
                        addr_err  <= err_q;
                        state     <= RESP;
                    end else begin
                        mem_clken <= 1'b1;
                        wait_cnt  <= 2'(READ_LATENCY - 1);
                        state     <= WAIT;
                    end
                end
                WAIT: begin
                    if (wait_cnt == '0) begin
                        mem_clken <= 1'b0;
                        rdata     <= mem_readdata;
                        resolved  <= grant_onehot;
                        addr_err  <= 1'b0;
                        state     <= RESP;
                    end else begin
                        wait_cnt <= wait_cnt - 1'b1;
                    end
                end
                RESP: begin
                    resolved <= '0;
                    addr_err <= 1'b0;
`ifdef PCM_MM_RESOLVER_STATS_EN
                    if (!err_q) begin
                        if (wr_q) begin
                            wr_count <= wr_count + 16'd1;
                        end else begin
                            rd_count <= rd_count + 16'd1;
                        end
                    end
`endif
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_pcm_mm_resolver.sv
// Self-checking bench for pcm_mm_resolver: directed scenarios plus random
// traffic, all checked against a transaction-level reference model.
module tb_pcm_mm_resolver #(
    parameter int RL = 1
);

    localparam int N        = 4;
    localparam int M_DIRECT = 0;
    localparam int M_FAIR   = 1;
    localparam int M_RAND   = 2;

    logic              clk = 1'b0;
    logic              reset;
    logic [N-1:0]      schedule;
    logic [N-1:0]      req_write;
    logic [N*20-1:0]   req_addr;
    logic [N*16-1:0]   req_wdata;
    logic [N-1:0]      resolved;
    logic [15:0]       rdata;
    logic              addr_err;
    logic [10:0]       mem_address;
    logic              mem_chipselect;
    logic              mem_clken;
    logic              mem_write;
    logic [15:0]       mem_writedata;
    logic [1:0]        mem_byteenable;
    logic [15:0]       mem_readdata;
`ifdef PCM_MM_RESOLVER_STATS_EN
    logic [15:0]       rd_count;
    logic [15:0]       wr_count;
`endif

    always #5 clk = ~clk;

    pcm_mm_resolver #(
        .NUM_REQ      (N),
        .READ_LATENCY (RL),
        .MEM_AW       (11)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .schedule       (schedule),
        .req_write      (req_write),
        .req_addr       (req_addr),
        .req_wdata      (req_wdata),
        .resolved       (resolved),
        .rdata          (rdata),
        .addr_err       (addr_err),
        .mem_address    (mem_address),
        .mem_chipselect (mem_chipselect),
        .mem_clken      (mem_clken),
        .mem_write      (mem_write),
        .mem_writedata  (mem_writedata),
        .mem_byteenable (mem_byteenable),
        .mem_readdata   (mem_readdata)
`ifdef PCM_MM_RESOLVER_STATS_EN
        ,
        .rd_count       (rd_count),
        .wr_count       (wr_count)
`endif
    );

    // ---------------- memory environment (2K x 16, RL-cycle read pipe) ----
    function automatic logic [15:0] init_val(input int unsigned a);
        if (a == 32'h123) return 16'hA5A5;
        return 16'(a * 40503 + 7);
    endfunction

    logic [15:0] mem_arr [0:2047];
    logic [15:0] pipe [0:RL-1];

    always @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < 2048; i++) mem_arr[i] <= init_val(i);
        end else if (mem_chipselect && mem_clken && mem_write) begin
            mem_arr[mem_address] <= mem_writedata;
        end
    end

    always @(posedge clk) begin
        if (mem_clken) begin
            pipe[0] <= mem_arr[mem_address];
            for (int i = 1; i < RL; i++) pipe[i] <= pipe[i-1];
        end
    end

    assign mem_readdata = pipe[RL-1];

    // ---------------- checking ------------------------------------------
    int errors = 0;
    int checks = 0;
    int cyc    = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // ---------------- reference model -----------------------------------
    typedef struct {
        int          ch;
        bit          wr;
        logic [19:0] addr;
        logic [15:0] data;
    } req_t;

    logic [15:0] ref_mem [0:2047];
    int          ptr;
    bit          busy;
    int          g;
    int          iss_cyc;
    int          exp_cyc;
    int          idle_from;
    bit          m_wr;
    bit          m_err;
    logic [10:0] m_addr;
    logic [15:0] m_wdata;
    logic [15:0] m_rdata;
    int          m_rd_cnt;
    int          m_wr_cnt;
    int          mode;
    int          grant_log[$];
    req_t        dq[$];
    logic [N-1:0] just_dropped;

    task automatic model_reset();
        ptr       = 0;
        busy      = 1'b0;
        idle_from = cyc + 1;
        m_rd_cnt  = 0;
        m_wr_cnt  = 0;
        for (int i = 0; i < 2048; i++) ref_mem[i] = init_val(i);
    endtask

    task automatic do_reset();
        reset    = 1'b1;
        schedule = '0;
        model_reset();
    endtask

    task automatic raise(input int ch, input bit wr, input logic [19:0] a, input logic [15:0] d);
        schedule[ch]          = 1'b1;
        req_write[ch]         = wr;
        req_addr[ch*20 +: 20] = a;
        req_wdata[ch*16 +: 16] = d;
    endtask

    function automatic logic [19:0] rand_addr();
        if ($urandom_range(0, 7) == 0) return 20'($urandom_range(2048, 20'hFFFFF));
        return 20'($urandom_range(0, 31));
    endfunction

    task automatic push_req(input int ch, input bit wr, input logic [19:0] a, input logic [15:0] d);
        req_t r;
        r.ch = ch; r.wr = wr; r.addr = a; r.data = d;
        dq.push_back(r);
    endtask

    // One clock cycle: observe at the falling edge, then drive and predict.
    task automatic tick();
        logic [N-1:0] exp_oh;
        logic [19:0]  a;
        bit           found;
        @(negedge clk);
        cyc++;
        reset        = 1'b0;
        just_dropped = '0;

        if (busy && cyc == iss_cyc) begin
            if (m_err) begin
                check("err_no_cs", 32'(mem_chipselect), 0);
                check("err_no_we", 32'(mem_write), 0);
            end else begin
                check("iss_cs_clken", 32'({mem_chipselect, mem_clken}), 32'b11);
                check("iss_we", 32'(mem_write), 32'(m_wr));
                check("iss_addr", 32'(mem_address), 32'(m_addr));
                if (m_wr) check("iss_wdata", 32'(mem_writedata), 32'(m_wdata));
            end
        end
        if (busy && !m_wr && !m_err && cyc > iss_cyc && cyc < exp_cyc)
            check("wait_strobes", 32'({mem_clken, mem_chipselect, mem_write}), 32'b100);

        if (busy && cyc == exp_cyc) begin
            exp_oh    = '0;
            exp_oh[g] = 1'b1;
            check("resolved", 32'(resolved), 32'(exp_oh));
            check("addr_err", 32'(addr_err), 32'(m_err));
            check("rdata", 32'(rdata), 32'(m_rdata));
            schedule[g]     = 1'b0;
            just_dropped[g] = 1'b1;
            busy            = 1'b0;
            idle_from       = cyc + 1;
            grant_log.push_back(g);
            if (!m_err) begin
                if (m_wr) m_wr_cnt++;
                else      m_rd_cnt++;
            end
        end else begin
            check("no_resolved", 32'(resolved), 0);
            check("no_addr_err", 32'(addr_err), 0);
        end

        case (mode)
            M_RAND: begin
                for (int ch = 0; ch < N; ch++)
                    if (!schedule[ch] && !just_dropped[ch] && $urandom_range(0, 3) == 0)
                        raise(ch, 1'($urandom_range(0, 1)), rand_addr(), 16'($urandom));
                if (busy) begin
                    req_addr[g*20 +: 20]  = rand_addr();
                    req_wdata[g*16 +: 16] = 16'($urandom);
                    req_write[g]          = 1'($urandom_range(0, 1));
                end
            end
            M_FAIR: begin
                for (int ch = 0; ch < N; ch++)
                    if (!schedule[ch] && !just_dropped[ch]) raise(ch, 1'b0, 20'(ch), 16'h0);
            end
            default: begin
                if (dq.size() > 0 && !schedule[dq[0].ch] && !just_dropped[dq[0].ch]) begin
                    raise(dq[0].ch, dq[0].wr, dq[0].addr, dq[0].data);
                    void'(dq.pop_front());
                end
            end
        endcase

        if (!busy && cyc >= idle_from && schedule != '0) begin
            found = 1'b0;
            for (int k = 0; k < N; k++) begin
                if (!found && schedule[(ptr + k) % N]) begin
                    g     = (ptr + k) % N;
                    found = 1'b1;
                end
            end
            ptr     = (g + 1) % N;
            busy    = 1'b1;
            a       = req_addr[g*20 +: 20];
            m_wr    = req_write[g];
            m_err   = (a >= 20'd2048);
            m_addr  = a[10:0];
            m_wdata = req_wdata[g*16 +: 16];
            iss_cyc = cyc + 1;
            if (m_err) begin
                m_rdata = 16'h0000;
            end else if (m_wr) begin
                ref_mem[m_addr] = m_wdata;
                m_rdata         = 16'h0000;
            end else begin
                m_rdata = ref_mem[m_addr];
            end
            exp_cyc = cyc + 2 + ((m_wr || m_err) ? 0 : RL);
        end
    endtask

    task automatic drain();
        int n;
        n = 0;
        while ((busy || schedule != '0 || dq.size() > 0) && n < 400) begin
            tick();
            n++;
        end
        if (n >= 400) check("drain_timeout", 0, 1);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_resolved"}, 32'(resolved), 0);
        check({tag, "_rdata"}, 32'(rdata), 0);
        check({tag, "_addr_err"}, 32'(addr_err), 0);
        check({tag, "_strobes"}, 32'({mem_chipselect, mem_clken, mem_write}), 0);
        check({tag, "_mem_addr"}, 32'(mem_address), 0);
        check({tag, "_mem_wdata"}, 32'(mem_writedata), 0);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int fair_exp [5];
        int n;
        fair_exp  = '{0, 1, 2, 3, 0};
        schedule  = '0;
        req_write = '0;
        req_addr  = '0;
        req_wdata = '0;
        mode      = M_DIRECT;
        do_reset();
        tick();
        check_reset_outputs("reset");
        check("byteenable", 32'(mem_byteenable), 32'b11);

        // Directed: write/read-back, out-of-range, range boundary, preload.
        push_req(0, 1'b1, 20'h00010, 16'h0FF0);
        push_req(0, 1'b0, 20'h00010, 16'h0000);
        push_req(2, 1'b0, 20'hFFFFF, 16'h0000);
        push_req(3, 1'b0, 20'h00123, 16'h0000);
        push_req(1, 1'b1, 20'h00800, 16'hDEAD);
        push_req(1, 1'b1, 20'h007FF, 16'h1234);
        push_req(2, 1'b0, 20'h007FF, 16'h0000);
        push_req(2, 1'b0, 20'h00800, 16'h0000);
        drain();

        // Fairness from a freshly reset pointer with all four requesting.
        do_reset();
        tick();
        grant_log.delete();
        mode = M_FAIR;
        n = 0;
        while (grant_log.size() < 5 && n < 200) begin
            tick();
            n++;
        end
        mode = M_DIRECT;
        drain();
        check("fair_count", 32'(grant_log.size() >= 5), 1);
        for (int i = 0; i < 5; i++)
            if (i < grant_log.size()) check($sformatf("fair_order%0d", i), 32'(grant_log[i]), 32'(fair_exp[i]));

        // Reset while a read is waiting on memory.
        push_req(1, 1'b0, 20'h00005, 16'h0000);
        n = 0;
        while (!(busy && cyc == iss_cyc + 1) && n < 50) begin
            tick();
            n++;
        end
        check("midread_reach_wait", 32'(n < 50), 1);
        do_reset();
        tick();
        check_reset_outputs("midread");
        repeat (RL + 3) tick();
        push_req(3, 1'b0, 20'h00123, 16'h0000);
        drain();

        // Random traffic.
        mode = M_RAND;
        repeat (3000) tick();
        mode = M_DIRECT;
        drain();

`ifdef PCM_MM_RESOLVER_STATS_EN
        check("rd_count", 32'(rd_count), 32'(m_rd_cnt[15:0]));
        check("wr_count", 32'(wr_count), 32'(m_wr_cnt[15:0]));
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
